// File: rtl/bpf_amplitude_detector.sv
// Peak-to-peak amplitude detector for the band-pass FIR output stream.
// Reports per-window max/min/amplitude and a hysteresis tone flag.
module bpf_amplitude_detector #(
  parameter int DW      = 21,
  parameter int WIN_LEN = 1024,
  parameter int SETTLE  = 8,
  parameter int TH_ON   = 4096,
  parameter int TH_OFF  = 2048
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_en,
  input  logic [DW-1:0] data_in,
  output logic          amp_valid,
  output logic [DW-1:0] amp_out,
  output logic [DW-1:0] peak_max,
  output logic [DW-1:0] peak_min,
  output logic          tone_present
);

  localparam int CW = $clog2(WIN_LEN);
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int SL = (SETTLE > 0) ? SETTLE - 1 : 0;

  localparam logic [CW-1:0] WIN_LAST = CW'(WIN_LEN - 1);
  localparam logic [SW-1:0] SET_LAST = SW'(SL);
  localparam logic [DW-1:0] ON_TH    = DW'(TH_ON);
  localparam logic [DW-1:0] OFF_TH   = DW'(TH_OFF);

  typedef enum logic [1:0] {
    IDLE,
    SETL,
    MEAS
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [SW-1:0] set_cnt;
  logic [SW-1:0] set_cnt_n;
  logic [CW-1:0] win_cnt;
  logic [DW-1:0] run_max;
  logic [DW-1:0] run_min;
  logic [DW-1:0] cur_max;
  logic [DW-1:0] cur_min;
  logic [DW-1:0] amp_n;
  logic          take;
  logic          seed;
  logic          close;

  // Next state: settle flush, then measure; in_en low aborts anywhere.
  always_comb begin
    state_n   = state;
    set_cnt_n = set_cnt;
    take      = 1'b0;
    unique case (state)
      IDLE: begin
        if (in_en) begin
          if (SETTLE == 0) begin
            take    = 1'b1;
            state_n = MEAS;
          end else if (SETTLE == 1) begin
            state_n = MEAS;
          end else begin
            state_n   = SETL;
            set_cnt_n = SW'(1);
          end
        end
      end
      SETL: begin
        if (!in_en) begin
          state_n   = IDLE;
          set_cnt_n = '0;
        end else if (set_cnt == SET_LAST) begin
          state_n   = MEAS;
          set_cnt_n = '0;
        end else begin
          set_cnt_n = set_cnt + 1'b1;
        end
      end
      MEAS: begin
        if (!in_en) state_n = IDLE;
        else        take    = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  // Running extremes including the current sample; index 0 re-seeds.
  always_comb begin
    seed    = (win_cnt == '0);
    cur_max = (seed || data_in > run_max) ? data_in : run_max;
    cur_min = (seed || data_in < run_min) ? data_in : run_min;
    close   = take && (win_cnt == WIN_LAST);
    amp_n   = cur_max - cur_min;
  end

  // Control state and settle counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      set_cnt <= '0;
    end else begin
      state   <= state_n;
      set_cnt <= set_cnt_n;
    end
  end

  // Window index and running extremes; cleared whenever not measuring.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt <= '0;
      run_max <= '0;
      run_min <= '1;
    end else if (take) begin
      win_cnt <= close ? '0 : win_cnt + 1'b1;
      run_max <= cur_max;
      run_min <= cur_min;
    end else begin
      win_cnt <= '0;
      run_max <= '0;
      run_min <= '1;
    end
  end

  // Result registers and hysteresis flag, updated on window close.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      amp_valid    <= 1'b0;
      amp_out      <= '0;
      peak_max     <= '0;
      peak_min     <= '0;
      tone_present <= 1'b0;
    end else begin
      amp_valid <= close;
      if (close) begin
        peak_max <= cur_max;
        peak_min <= cur_min;
        amp_out  <= amp_n;
        if (amp_n >= ON_TH)      tone_present <= 1'b1;
        else if (amp_n < OFF_TH) tone_present <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bpf_amplitude_detector.sv
// Scoreboard bench for bpf_amplitude_detector.
// Directed windows with hand-computed results.
module tb_bpf_amplitude_detector;

  localparam int DW = 21;

  logic          clk;
  logic          rst_n;
  logic          in_en;
  logic [DW-1:0] data_in;
  logic          amp_valid;
  logic [DW-1:0] amp_out;
  logic [DW-1:0] peak_max;
  logic [DW-1:0] peak_min;
  logic          tone_present;

  bpf_amplitude_detector #(
    .DW(DW),
    .WIN_LEN(16),
    .SETTLE(4),
    .TH_ON(1000),
    .TH_OFF(500)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_en(in_en),
    .data_in(data_in),
    .amp_valid(amp_valid),
    .amp_out(amp_out),
    .peak_max(peak_max),
    .peak_min(peak_min),
    .tone_present(tone_present)
  );

  typedef struct {
    logic [DW-1:0] mx;
    logic [DW-1:0] mn;
    logic [DW-1:0] amp;
    logic          tone;
    int            cyc;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: every result pulse is matched against the queue head.
  always @(negedge clk) begin
    if (amp_valid === 1'b1) begin
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_valid: pulse at cycle %0d, expected none", cyc);
      end else begin
        e = q.pop_front();
        chk("valid_cycle", cyc, e.cyc);
        chk("peak_max", 32'(peak_max), 32'(e.mx));
        chk("peak_min", 32'(peak_min), 32'(e.mn));
        chk("amp_out", 32'(amp_out), 32'(e.amp));
        chk("tone_present", 32'(tone_present), 32'(e.tone));
      end
    end
  end

  task automatic push(input logic [DW-1:0] mx, input logic [DW-1:0] mn,
                      input logic [DW-1:0] amp, input logic tone);
    exp_t x;
    x.mx   = mx;
    x.mn   = mn;
    x.amp  = amp;
    x.tone = tone;
    x.cyc  = cyc + 1;
    q.push_back(x);
  endtask

  task automatic feed(input logic [DW-1:0] d);
    in_en   = 1'b1;
    data_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_en = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic win(input logic [DW-1:0] a, input logic [DW-1:0] b,
                     input logic [DW-1:0] mx, input logic [DW-1:0] mn,
                     input logic [DW-1:0] amp, input logic tone);
    for (int i = 0; i < 16; i++) begin
      if (i == 15) push(mx, mn, amp, tone);
      feed((i % 2) ? b : a);
    end
  endtask

  task automatic chk_outs(input string nm, input logic [DW-1:0] mx,
                          input logic [DW-1:0] mn, input logic [DW-1:0] amp,
                          input logic tone);
    chk({nm, "_max"}, 32'(peak_max), 32'(mx));
    chk({nm, "_min"}, 32'(peak_min), 32'(mn));
    chk({nm, "_amp"}, 32'(amp_out), 32'(amp));
    chk({nm, "_tone"}, 32'(tone_present), 32'(tone));
    chk({nm, "_valid"}, 32'(amp_valid), 32'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n   = 1'b0;
    in_en   = 1'b0;
    data_in = '0;
    repeat (4) begin
      @(posedge clk);
      #1;
      in_en   = 1'($urandom_range(0, 1));
      data_in = DW'($urandom);
      @(negedge clk);
      chk_outs("reset", '0, '0, '0, 1'b0);
    end
    @(posedge clk);
    #1;
    in_en = 1'b0;
    rst_n = 1'b1;
    idle(2);

    for (int i = 0; i < 20; i++) begin
      if (i == 19) push(5000, 5000, 0, 1'b0);
      feed(5000);
    end
    idle(3);
    chk("const_queue", q.size(), 0);

    repeat (4) feed(20000);
    repeat (3) win(10000, 8000, 10000, 8000, 2000, 1'b1);
    win(10000, 9300, 10000, 9300, 700, 1'b1);
    win(10000, 9600, 10000, 9600, 400, 1'b0);

    for (int i = 0; i < 10; i++) feed((i % 2) ? 21'd100 : 21'd10000);
    repeat (3) begin
      idle(1);
      chk_outs("hold", 10000, 9600, 400, 1'b0);
    end
    repeat (4) feed(0);
    win(3000, 1000, 3000, 1000, 2000, 1'b1);
    idle(2);

    repeat (4) feed(50000);
    win(0, 2097151, 2097151, 0, 2097151, 1'b1);
    repeat (8) feed(123);
    #3;
    rst_n = 1'b0;
    #1;
    chk_outs("midrst", '0, '0, '0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (12) feed(777);
    idle(8);
    chk("final_queue", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
